// File: rtl/grf_writeback_ctrl.sv
// GRF single write-port controller: W-stage writes take priority, mul/div results drain from a FIFO.
// Optional per-write trace print when GRF_WB_TRACE_EN is defined.
module grf_writeback_ctrl #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     w_valid,
  input  logic [31:0]              w_pc,
  input  logic [4:0]               w_addr,
  input  logic [31:0]              w_data,
  input  logic                     md_valid,
  output logic                     md_ready,
  input  logic [31:0]              md_pc,
  input  logic [4:0]               md_addr,
  input  logic [31:0]              md_data,
  input  logic                     md_issue,
  input  logic [4:0]               md_issue_addr,
  input  logic [4:0]               rd_addr1,
  input  logic [4:0]               rd_addr2,
  output logic                     rd_busy1,
  output logic                     rd_busy2,
  output logic                     grf_we,
  output logic [31:0]              grf_pc,
  output logic [4:0]               grf_addr,
  output logic [31:0]              grf_wd,
  output logic [$clog2(DEPTH):0]   fifo_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [31:0]   fifo_pc   [DEPTH];
  logic [4:0]    fifo_addr [DEPTH];
  logic [31:0]   fifo_data [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [31:0]   pend;
  logic [31:0]   pend_nxt;

  logic          w_take;
  logic          pop;
  logic          push;
  logic [31:0]   sel_pc;
  logic [4:0]    sel_addr;
  logic [31:0]   sel_wd;

  // Ready comes only from the registered count, so a full FIFO never pushes even while popping.
  assign md_ready = (fifo_count != CW'(DEPTH));
  assign w_take   = w_valid && (w_addr != 5'd0);
  assign pop      = !w_take && (fifo_count != '0);
  assign push     = md_valid && md_ready && (md_addr != 5'd0);

  assign sel_pc   = w_take ? w_pc   : fifo_pc[rd_ptr];
  assign sel_addr = w_take ? w_addr : fifo_addr[rd_ptr];
  assign sel_wd   = w_take ? w_data : fifo_data[rd_ptr];

  assign rd_busy1 = pend[rd_addr1];
  assign rd_busy2 = pend[rd_addr2];

  // Clear on pop first so a same-cycle issue to that register wins.
  always_comb begin
    pend_nxt = pend;
    if (pop) pend_nxt[fifo_addr[rd_ptr]] = 1'b0;
    if (md_issue) pend_nxt[md_issue_addr] = 1'b1;
    pend_nxt[0] = 1'b0;
  end

  // FIFO payload storage carries no reset; occupancy is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_pc[wr_ptr]   <= md_pc;
      fifo_addr[wr_ptr] <= md_addr;
      fifo_data[wr_ptr] <= md_data;
    end
  end

  // Write-port output stage
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      pend       <= '0;
      grf_we     <= 1'b0;
      grf_pc     <= '0;
      grf_addr   <= '0;
      grf_wd     <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
      pend   <= pend_nxt;
      grf_we <= w_take || pop;
      if (w_take || pop) begin
        grf_pc   <= sel_pc;
        grf_addr <= sel_addr;
        grf_wd   <= sel_wd;
      end
    end
  end

`ifdef GRF_WB_TRACE_EN
  always @(posedge clk) begin
    if (reset && (w_take || pop))
      $display("%d@%h: $%d <= %h", $time, sel_pc, sel_addr, sel_wd);
  end
`endif

endmodule

// File: tb/tb_grf_writeback_ctrl.sv
// Bench for grf_writeback_ctrl: directed steps then random traffic against a queue-based model.
module tb_grf_writeback_ctrl;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        w_valid = 1'b0;
  logic [31:0] w_pc = '0;
  logic [4:0]  w_addr = '0;
  logic [31:0] w_data = '0;
  logic        md_valid = 1'b0;
  logic        md_ready;
  logic [31:0] md_pc = '0;
  logic [4:0]  md_addr = '0;
  logic [31:0] md_data = '0;
  logic        md_issue = 1'b0;
  logic [4:0]  md_issue_addr = '0;
  logic [4:0]  rd_addr1 = '0;
  logic [4:0]  rd_addr2 = '0;
  logic        rd_busy1;
  logic        rd_busy2;
  logic        grf_we;
  logic [31:0] grf_pc;
  logic [4:0]  grf_addr;
  logic [31:0] grf_wd;
  logic [2:0]  fifo_count;

  grf_writeback_ctrl #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .w_valid(w_valid), .w_pc(w_pc), .w_addr(w_addr), .w_data(w_data),
    .md_valid(md_valid), .md_ready(md_ready), .md_pc(md_pc), .md_addr(md_addr), .md_data(md_data),
    .md_issue(md_issue), .md_issue_addr(md_issue_addr),
    .rd_addr1(rd_addr1), .rd_addr2(rd_addr2), .rd_busy1(rd_busy1), .rd_busy2(rd_busy2),
    .grf_we(grf_we), .grf_pc(grf_pc), .grf_addr(grf_addr), .grf_wd(grf_wd),
    .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [4:0]  addr;
    logic [31:0] data;
  } ent_t;

  ent_t        q[$];
  logic [31:0] m_pend = '0;
  logic        m_we = 1'b0;
  logic [31:0] m_pc = '0;
  logic [4:0]  m_addr = '0;
  logic [31:0] m_wd = '0;
  int          errors = 0;
  int          checks = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".we"},    {31'd0, grf_we},   {31'd0, m_we});
    chk({tag, ".addr"},  {27'd0, grf_addr}, {27'd0, m_addr});
    chk({tag, ".wd"},    grf_wd,            m_wd);
    chk({tag, ".pc"},    grf_pc,            m_pc);
    chk({tag, ".count"}, {29'd0, fifo_count}, q.size());
    chk({tag, ".ready"}, {31'd0, md_ready}, (q.size() < DEPTH) ? 32'd1 : 32'd0);
    chk({tag, ".busy1"}, {31'd0, rd_busy1}, {31'd0, m_pend[rd_addr1]});
    chk({tag, ".busy2"}, {31'd0, rd_busy2}, {31'd0, m_pend[rd_addr2]});
  endtask

  // Apply one clock with the currently driven inputs, advancing the model by the written rules.
  task automatic cyc(input string tag);
    ent_t e;
    bit   room;
    room = (q.size() < DEPTH);
    if (w_valid && w_addr != 0) begin
      m_we = 1'b1; m_pc = w_pc; m_addr = w_addr; m_wd = w_data;
    end else if (q.size() > 0) begin
      e = q.pop_front();
      m_we = 1'b1; m_pc = e.pc; m_addr = e.addr; m_wd = e.data;
      m_pend[e.addr] = 1'b0;
    end else begin
      m_we = 1'b0;
    end
    if (md_valid && room && md_addr != 0) begin
      e.pc = md_pc; e.addr = md_addr; e.data = md_data;
      q.push_back(e);
    end
    if (md_issue && md_issue_addr != 0) m_pend[md_issue_addr] = 1'b1;
    @(posedge clk);
    #1;
    check_all(tag);
    w_valid = 1'b0; md_valid = 1'b0; md_issue = 1'b0;
  endtask

  task automatic model_reset();
    q.delete();
    m_pend = '0; m_we = 1'b0; m_pc = '0; m_addr = '0; m_wd = '0;
  endtask

  initial begin
    #12;
    chk("rst.we", {31'd0, grf_we}, 32'd0);
    chk("rst.count", {29'd0, fifo_count}, 32'd0);
    chk("rst.ready", {31'd0, md_ready}, 32'd1);
    chk("rst.wd", grf_wd, 32'd0);
    #1 reset = 1'b1;

    // W write with latency one
    w_valid = 1'b1; w_addr = 5'd5; w_data = 32'h1234; w_pc = 32'h3000;
    cyc("w5");
    chk("w5.addr_const", {27'd0, grf_addr}, 32'd5);
    chk("w5.wd_const", grf_wd, 32'h1234);
    chk("w5.pc_const", grf_pc, 32'h3000);
    cyc("w5.idle");
    chk("w5.we_one_cycle", {31'd0, grf_we}, 32'd0);

    // Scoreboard set, then result lands and clears it in the write cycle
    rd_addr1 = 5'd8; rd_addr2 = 5'd0;
    md_issue = 1'b1; md_issue_addr = 5'd8;
    cyc("iss8");
    chk("iss8.busy", {31'd0, rd_busy1}, 32'd1);
    md_valid = 1'b1; md_addr = 5'd8; md_data = 32'hABCD; md_pc = 32'h3004;
    cyc("push8");
    chk("push8.busy_held", {31'd0, rd_busy1}, 32'd1);
    cyc("pop8");
    chk("pop8.wd_const", grf_wd, 32'hABCD);
    chk("pop8.busy_clr", {31'd0, rd_busy1}, 32'd0);

    // Fill under continuous W traffic, stall the fifth, then drain in order
    for (int i = 0; i < 5; i++) begin
      w_valid = 1'b1; w_addr = 5'(1 + i); w_data = 32'h100 + i; w_pc = 32'h4000 + 4 * i;
      md_valid = 1'b1; md_addr = 5'(10 + i); md_data = 32'hA0 + i; md_pc = 32'h5000 + 4 * i;
      cyc("fill");
    end
    chk("full.count", {29'd0, fifo_count}, 32'd4);
    chk("full.ready", {31'd0, md_ready}, 32'd0);
    md_valid = 1'b1; md_addr = 5'd14; md_data = 32'hA4;
    cyc("full.pop_no_push");
    chk("full.pop_count", {29'd0, fifo_count}, 32'd3);
    chk("full.pop_ready", {31'd0, md_ready}, 32'd1);
    chk("drain0", {27'd0, grf_addr}, 32'd10);
    for (int i = 1; i < 4; i++) begin
      cyc("drain");
      chk("drain.addr", {27'd0, grf_addr}, 32'(10 + i));
      chk("drain.wd", grf_wd, 32'hA0 + i);
    end
    cyc("drained");

    // Register zero is never written nor stored
    w_valid = 1'b1; w_addr = 5'd0; w_data = 32'hDEAD;
    md_valid = 1'b1; md_addr = 5'd0; md_data = 32'hBEEF;
    cyc("zero");
    chk("zero.we", {31'd0, grf_we}, 32'd0);
    chk("zero.count", {29'd0, fifo_count}, 32'd0);

    // Reset mid-operation with queued entries and pending bits
    rd_addr1 = 5'd20; rd_addr2 = 5'd21;
    md_issue = 1'b1; md_issue_addr = 5'd20;
    cyc("pre_rst.a");
    md_issue = 1'b1; md_issue_addr = 5'd21;
    w_valid = 1'b1; w_addr = 5'd3; md_valid = 1'b1; md_addr = 5'd20; md_data = 32'h77;
    cyc("pre_rst.b");
    w_valid = 1'b1; w_addr = 5'd4; md_valid = 1'b1; md_addr = 5'd21; md_data = 32'h78;
    cyc("pre_rst.c");
    chk("pre_rst.count", {29'd0, fifo_count}, 32'd2);
    #2 reset = 1'b0;
    #1;
    chk("mid_rst.count", {29'd0, fifo_count}, 32'd0);
    chk("mid_rst.we", {31'd0, grf_we}, 32'd0);
    chk("mid_rst.busy1", {31'd0, rd_busy1}, 32'd0);
    chk("mid_rst.busy2", {31'd0, rd_busy2}, 32'd0);
    model_reset();
    @(posedge clk);
    #1 reset = 1'b1;
    for (int i = 0; i < 3; i++) cyc("post_rst");

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      w_valid = ($urandom_range(0, 99) < 55);
      w_addr = ($urandom_range(0, 9) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      w_data = $urandom; w_pc = $urandom;
      md_valid = ($urandom_range(0, 99) < 45);
      md_addr = ($urandom_range(0, 9) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      md_data = $urandom; md_pc = $urandom;
      md_issue_addr = 5'($urandom_range(0, 31));
      md_issue = ($urandom_range(0, 99) < 30) && !m_pend[md_issue_addr];
      rd_addr1 = 5'($urandom_range(0, 31));
      rd_addr2 = 5'($urandom_range(0, 31));
      cyc("rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/grf_writeback_ctrl.md
# grf_writeback_ctrl

Write-side controller for the general register file's single write port. Merges in-order writebacks from the W pipeline stage with out-of-order results from the long-latency multiply/divide unit, which are buffered in a small FIFO. Tracks registers with outstanding multi-cycle results in a scoreboard so decode can stall. Drives the GRF write port (enable, PC, address, data) from registered outputs.

## Interface
- DEPTH, 4, FIFO entries for multiply/divide results; power of two, 2..16
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- w_valid  in  1  W-stage write request this cycle
- w_pc  in  32  PC of the W-stage instruction
- w_addr  in  5  W-stage destination register
- w_data  in  32  W-stage write data
- md_valid  in  1  multiply/divide result offered
- md_ready  out  1  FIFO can accept; equals count < DEPTH
- md_pc  in  32  PC of the producing instruction
- md_addr  in  5  result destination register
- md_data  in  32  result data
- md_issue  in  1  multi-cycle op issued this cycle
- md_issue_addr  in  5  its destination register
- rd_addr1  in  5  decode lookup address, operand 1
- rd_addr2  in  5  decode lookup address, operand 2
- rd_busy1  out  1  pending bit for rd_addr1, combinational
- rd_busy2  out  1  pending bit for rd_addr2, combinational
- grf_we  out  1  GRF write enable, registered
- grf_pc  out  32  GRF trace PC, registered
- grf_addr  out  5  GRF write address, registered
- grf_wd  out  32  GRF write data, registered
- fifo_count  out  $clog2(DEPTH)+1  FIFO occupancy

## Operation
- Reset (async, reset=0):
  - grf_we, grf_pc, grf_addr, grf_wd, fifo_count and all pending bits go to 0.
  - md_ready goes to 1.
- Port select, evaluated each cycle; the chosen source is loaded into the output registers:
  - If w_valid and w_addr != 0, the W request wins, always accepted; there is no backpressure on W.
  - Otherwise, if the FIFO is non-empty, the head entry is popped.
  - Otherwise grf_we = 0; grf_addr, grf_wd and grf_pc hold their values.
- W requests with w_addr = 0 are dropped; no write occurs and the FIFO may drain that cycle.
- FIFO push:
  - A push happens on md_valid && md_ready.
  - md_addr = 0 is handshaken but not stored.
  - md_ready depends only on the registered count. When full, no push occurs even if a pop happens in the same cycle.
- Push and pop in the same cycle leave the count unchanged. Pointers wrap modulo DEPTH.
- Scoreboard: 32 pending bits; bit 0 is always 0.
  - A bit is set on md_issue with md_issue_addr != 0.
  - A bit is cleared when a FIFO entry for that register is popped to the write port.
  - If set and clear hit the same register in the same cycle, set wins.
  - Decode must not issue to a busy register; behaviour in that case is undefined.
- W has strict priority; the FIFO drains only on W bubbles. Starvation is permitted.
- rd_busy reflects the registered pending bits; there is no bypass of same-cycle md_issue.

## Timing
- W request accepted at edge N appears on grf_* after edge N; latency 1.
- FIFO entry pushed at edge N is poppable from cycle N+1 and reaches the port at edge N+1 at the earliest.
- The pending bit clears at the same edge that loads grf_we = 1 for that entry. rd_busy drops in that cycle, which aligns with the GRF write-through bypass.
- grf_we is high for exactly one cycle per write.
- Reset asserted mid-operation discards FIFO contents and pending bits immediately.

## Configuration
- GRF_WB_TRACE_EN: when defined, prints one line per write at the clock edge where grf_we rises, formatted as "%d@%h: $%d <= %h" with time, grf_pc, grf_addr and grf_wd.
- When undefined, no $display is compiled and the logic is identical otherwise.

## Test plan
- Reset release, then w_valid, w_addr=5, w_data=0x1234, w_pc=0x3000 -> next cycle grf_we=1, grf_addr=5, grf_wd=0x1234, grf_pc=0x3000.
- md_issue addr=8 -> rd_busy1=1 for rd_addr1=8. Then md push addr=8, data=0xABCD with W idle -> write appears one cycle later and rd_busy1=0 in that same cycle.
- W busy every cycle while 4 md pushes arrive (DEPTH=4) -> fifo_count=4, md_ready=0, fifth push stalls. W stops -> 4 writes in push order on consecutive cycles.
- w_addr=0 and md_addr=0 requests -> grf_we stays 0 and fifo_count is unchanged.
- Full FIFO with simultaneous pop and md_valid -> no push that cycle, count goes to 3, md_ready=1 next cycle.
- Assert reset with 2 entries queued and pending bits set -> fifo_count=0, rd_busy=0, grf_we=0 immediately, and no stale writes after release.
